// File: rtl/ovl_fire_pkg.sv
// Shared definitions for the frame-checker fire logger: fire bit positions and the record layout.
package ovl_fire_pkg;

    localparam int FIRE_2STATE = 0;
    localparam int FIRE_XZ     = 1;
    localparam int FIRE_COVER  = 2;
    localparam int FIRE_W      = 3;
    localparam int REC_STAMP_W = 32;

    typedef logic [FIRE_W-1:0] fire_t;

    typedef struct packed {
        fire_t                  fire;
        logic [REC_STAMP_W-1:0] stamp;
    } fire_rec_t;

endpackage

// File: rtl/ovl_fire_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module ovl_fire_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads zero when empty so the record port shows clean values after reset.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ovl_frame_fire_logger.sv
// Fire-vector logger: saturating per-class counters plus a FIFO of timestamped firing-cycle records.
// Define OVL_FIRE_STAMP_EN to build the cycle stamp counter and per-record stamp storage.
module ovl_frame_fire_logger
    import ovl_fire_pkg::*;
#(
    parameter int STAMP_W    = 32,
    parameter int CNT_W      = 16,
    parameter int DEPTH      = 4,
    parameter int MAX_REPORT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [2:0]         fire,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [2:0]         rec_fire,
    output logic [STAMP_W-1:0] rec_stamp,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   xz_count,
    output logic [CNT_W-1:0]   cov_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow,
    output logic               limit_reached
);

`ifdef OVL_FIRE_STAMP_EN
    localparam int REC_W = FIRE_W + STAMP_W;
`else
    localparam int REC_W = FIRE_W;
`endif

    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] push_data, head_data;
    logic             event_cyc, pop, try_push, push_ok, drop;
    logic [CNT_W-1:0] err_q, err_d, xz_q, xz_d, cov_q, cov_d, drop_q, drop_d;
    logic             overflow_q, overflow_d, limit_q, limit_d;
    logic [31:0]      tally_q, tally_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        return (hit && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    assign event_cyc = enable & (|fire);
    assign rec_valid = ~fifo_empty;
    assign pop       = rec_valid & rec_ready;
    // Once the limit is hit, events only count; they are neither pushed nor dropped.
    assign try_push  = event_cyc & ~limit_q;
    assign push_ok   = try_push & (~fifo_full | pop);
    assign drop      = try_push & ~push_ok;

    always_comb begin
        err_d      = sat_inc(err_q, event_cyc & fire[FIRE_2STATE]);
        xz_d       = sat_inc(xz_q, event_cyc & fire[FIRE_XZ]);
        cov_d      = sat_inc(cov_q, event_cyc & fire[FIRE_COVER]);
        drop_d     = sat_inc(drop_q, drop);
        overflow_d = overflow_q | drop;
        tally_d    = tally_q;
        limit_d    = limit_q;
        if ((MAX_REPORT != 0) && push_ok) begin
            tally_d = tally_q + 32'd1;
            if (tally_d == 32'(MAX_REPORT)) begin
                limit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= '0;
            xz_q       <= '0;
            cov_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            limit_q    <= 1'b0;
            tally_q    <= '0;
        end else begin
            err_q      <= err_d;
            xz_q       <= xz_d;
            cov_q      <= cov_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            limit_q    <= limit_d;
            tally_q    <= tally_d;
        end
    end

`ifdef OVL_FIRE_STAMP_EN
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    always_comb begin
        stamp_d = stamp_q + STAMP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_d;
        end
    end

    assign push_data = {fire, stamp_q};
    assign rec_fire  = head_data[REC_W-1 -: FIRE_W];
    assign rec_stamp = head_data[STAMP_W-1:0];
`else
    assign push_data = fire;
    assign rec_fire  = head_data;
    assign rec_stamp = '0;
`endif

    ovl_fire_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_data)
    );

    assign err_count     = err_q;
    assign xz_count      = xz_q;
    assign cov_count     = cov_q;
    assign drop_count    = drop_q;
    assign overflow      = overflow_q;
    assign limit_reached = limit_q;

endmodule

// File: tb/tb_ovl_frame_fire_logger.sv
// Bench for ovl_frame_fire_logger: three configurations driven in lockstep against a queue-based reference model.
module tb_ovl_frame_fire_logger;
    import ovl_fire_pkg::*;

`ifdef OVL_FIRE_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    // ---------------- clock / reset / inputs ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       rec_ready = 1'b0;
    logic [2:0] fire = 3'b000;

    always #5 clk = ~clk;

    // ---------------- observed outputs, one slot per instance ----------------
    // d0: defaults; d1: MAX_REPORT=3; d2: CNT_W=2.
    logic        valid_o [3];
    logic [2:0]  fire_o  [3];
    logic [31:0] stamp_o [3];
    logic [15:0] cnt_o   [3][4];
    logic        ovf_o   [3];
    logic        lim_o   [3];
    logic [1:0]  c_err, c_xz, c_cov, c_drop;

    assign cnt_o[2][0] = {14'b0, c_err};
    assign cnt_o[2][1] = {14'b0, c_xz};
    assign cnt_o[2][2] = {14'b0, c_cov};
    assign cnt_o[2][3] = {14'b0, c_drop};

    ovl_frame_fire_logger #(.STAMP_W(32), .CNT_W(16), .DEPTH(4), .MAX_REPORT(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire),
        .rec_valid(valid_o[0]), .rec_ready(rec_ready), .rec_fire(fire_o[0]), .rec_stamp(stamp_o[0]),
        .err_count(cnt_o[0][0]), .xz_count(cnt_o[0][1]), .cov_count(cnt_o[0][2]), .drop_count(cnt_o[0][3]),
        .overflow(ovf_o[0]), .limit_reached(lim_o[0])
    );

    ovl_frame_fire_logger #(.STAMP_W(32), .CNT_W(16), .DEPTH(4), .MAX_REPORT(3)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire),
        .rec_valid(valid_o[1]), .rec_ready(rec_ready), .rec_fire(fire_o[1]), .rec_stamp(stamp_o[1]),
        .err_count(cnt_o[1][0]), .xz_count(cnt_o[1][1]), .cov_count(cnt_o[1][2]), .drop_count(cnt_o[1][3]),
        .overflow(ovf_o[1]), .limit_reached(lim_o[1])
    );

    ovl_frame_fire_logger #(.STAMP_W(32), .CNT_W(2), .DEPTH(4), .MAX_REPORT(0)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .fire(fire),
        .rec_valid(valid_o[2]), .rec_ready(rec_ready), .rec_fire(fire_o[2]), .rec_stamp(stamp_o[2]),
        .err_count(c_err), .xz_count(c_xz), .cov_count(c_cov), .drop_count(c_drop),
        .overflow(ovf_o[2]), .limit_reached(lim_o[2])
    );

    // ---------------- reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    fire_rec_t   exp_q0[$], exp_q1[$], exp_q2[$];
    int          cnt_m [3][4];
    bit          ovf_m [3];
    bit          lim_m [3];
    int          acc_m [3];
    logic [31:0] stamp_m;

    function automatic int max_report(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 2) ? 3 : 65535;
    endfunction

    function automatic int q_size(input int i);
        if (i == 0) return exp_q0.size();
        if (i == 1) return exp_q1.size();
        return exp_q2.size();
    endfunction

    function automatic fire_rec_t q_front(input int i);
        if (i == 0) return exp_q0[0];
        if (i == 1) return exp_q1[0];
        return exp_q2[0];
    endfunction

    task automatic q_push(input int i, input fire_rec_t r);
        if (i == 0) exp_q0.push_back(r);
        else if (i == 1) exp_q1.push_back(r);
        else exp_q2.push_back(r);
    endtask

    task automatic q_pop(input int i);
        if (i == 0) void'(exp_q0.pop_front());
        else if (i == 1) void'(exp_q1.pop_front());
        else void'(exp_q2.pop_front());
    endtask

    task automatic q_clear(input int i);
        if (i == 0) exp_q0.delete();
        else if (i == 1) exp_q1.delete();
        else exp_q2.delete();
    endtask

    // One clock edge of the specified behaviour for instance i, using the pre-edge stamp.
    task automatic model_step(input int i, input bit rst, input bit en, input logic [2:0] f, input bit rdy);
        int        sz;
        bit        pop_m;
        fire_rec_t r;
        if (rst) begin
            q_clear(i);
            for (int k = 0; k < 4; k++) cnt_m[i][k] = 0;
            ovf_m[i] = 1'b0;
            lim_m[i] = 1'b0;
            acc_m[i] = 0;
            return;
        end
        sz    = q_size(i);
        pop_m = (sz > 0) && rdy;
        if (en && (f != 3'b000)) begin
            for (int k = 0; k < 3; k++)
                if (f[k] && cnt_m[i][k] < cnt_max(i)) cnt_m[i][k]++;
            if (!lim_m[i]) begin
                if (sz < 4 || pop_m) begin
                    r.fire  = f;
                    r.stamp = stamp_m;
                    q_push(i, r);
                    acc_m[i]++;
                    if (max_report(i) > 0 && acc_m[i] == max_report(i)) lim_m[i] = 1'b1;
                end else begin
                    if (cnt_m[i][3] < cnt_max(i)) cnt_m[i][3]++;
                    ovf_m[i] = 1'b1;
                end
            end
        end
        if (pop_m) q_pop(i);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        string     nm [4];
        fire_rec_t r;
        nm = '{"err_count", "xz_count", "cov_count", "drop_count"};
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("d%0d.rec_valid", i), 64'(valid_o[i]), 64'(q_size(i) > 0));
            if (q_size(i) > 0) begin
                r = q_front(i);
                check_val($sformatf("d%0d.rec_fire", i), 64'(fire_o[i]), 64'(r.fire));
                check_val($sformatf("d%0d.rec_stamp", i), 64'(stamp_o[i]), STAMP_EN ? 64'(r.stamp) : 64'd0);
            end
            for (int k = 0; k < 4; k++)
                check_val($sformatf("d%0d.%s", i, nm[k]), 64'(cnt_o[i][k]), 64'(cnt_m[i][k]));
            check_val($sformatf("d%0d.overflow", i), 64'(ovf_o[i]), 64'(ovf_m[i]));
            check_val($sformatf("d%0d.limit_reached", i), 64'(lim_o[i]), 64'(lim_m[i]));
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rst, input bit en, input logic [2:0] f, input bit rdy);
        reset     = rst;
        enable    = en;
        fire      = f;
        rec_ready = rdy;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, rst, en, f, rdy);
        stamp_m = rst ? 32'd0 : stamp_m + 32'd1;
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 3'b000, rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        stamp_m = 32'd0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        check_val("reset.rec_valid", 64'(valid_o[0]), 64'd0);
        check_val("reset.rec_fire", 64'(fire_o[0]), 64'd0);
        check_val("reset.rec_stamp", 64'(stamp_o[0]), 64'd0);

        // Single event at stamp 5.
        for (int j = 0; j < 10 && stamp_m != 32'd5; j++) cycle(1'b0, 1'b0, 3'b000, 1'b1);
        cycle(1'b0, 1'b1, 3'b001, 1'b1);
        check_val("single.rec_valid", 64'(valid_o[0]), 64'd1);
        check_val("single.rec_fire", 64'(fire_o[0]), 64'd1);
        check_val("single.rec_stamp", 64'(stamp_o[0]), STAMP_EN ? 64'd5 : 64'd0);
        check_val("single.err_count", 64'(cnt_o[0][0]), 64'd1);
        check_val("single.xz_count", 64'(cnt_o[0][1]), 64'd0);
        idle(2, 1'b1);

        // Overflow: six events into a stalled FIFO, then drain.
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int j = 0; j < 6; j++) cycle(1'b0, 1'b1, 3'($urandom_range(1, 7)), 1'b0);
        check_val("ovf.drop_count", 64'(cnt_o[0][3]), 64'd2);
        check_val("ovf.overflow", 64'(ovf_o[0]), 64'd1);
        idle(5, 1'b1);
        check_val("ovf.drained", 64'(valid_o[0]), 64'd0);

        // Full FIFO with push and pop in the same cycle.
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int j = 0; j < 4; j++) cycle(1'b0, 1'b1, 3'b010, 1'b0);
        cycle(1'b0, 1'b1, 3'b100, 1'b1);
        check_val("fullpop.drop_count", 64'(cnt_o[0][3]), 64'd0);
        check_val("fullpop.overflow", 64'(ovf_o[0]), 64'd0);
        idle(6, 1'b1);

        // Report limit on d1.
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int j = 0; j < 5; j++) cycle(1'b0, 1'b1, 3'b110, 1'b0);
        check_val("limit.limit_reached", 64'(lim_o[1]), 64'd1);
        check_val("limit.xz_count", 64'(cnt_o[1][1]), 64'd5);
        check_val("limit.cov_count", 64'(cnt_o[1][2]), 64'd5);
        check_val("limit.drop_count", 64'(cnt_o[1][3]), 64'd0);
        check_val("limit.d0_no_limit", 64'(lim_o[0]), 64'd0);
        idle(5, 1'b1);

        // Enable low, then saturation on d2.
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 3'b111, 1'b1);
        check_val("enable.rec_valid", 64'(valid_o[0]), 64'd0);
        check_val("enable.err_count", 64'(cnt_o[0][0]), 64'd0);
        for (int j = 0; j < 5; j++) cycle(1'b0, 1'b1, 3'b001, 1'b1);
        check_val("sat.d2_err_count", 64'(cnt_o[2][0]), 64'd3);
        check_val("sat.d0_err_count", 64'(cnt_o[0][0]), 64'd5);
        idle(2, 1'b1);

        // Reset mid-operation, with an event presented in the reset cycle.
        for (int j = 0; j < 2; j++) cycle(1'b0, 1'b1, 3'b011, 1'b0);
        cycle(1'b1, 1'b1, 3'b111, 1'b1);
        check_val("midrst.rec_valid", 64'(valid_o[0]), 64'd0);
        check_val("midrst.err_count", 64'(cnt_o[0][0]), 64'd0);
        cycle(1'b0, 1'b1, 3'b010, 1'b0);
        check_val("midrst.rec_stamp", 64'(stamp_o[0]), 64'd0);
        check_val("midrst.rec_fire", 64'(fire_o[0]), 64'd2);
        idle(2, 1'b1);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 800; j++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
